// File: rtl/sharpen_pad_writer_if.sv
// Stream-in / memory-write bundle for the sharpen pad writer.
// The slave side is the writer block; the master side drives pixels and
// start, and observes the memory write port and frame status.
interface sharpen_pad_writer_if #(
   parameter int AW = 19
);
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          done;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, busy, done
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/sharpen_pad_writer.sv
// Writes a raw IMG_W x IMG_H pixel stream into memory as a zero-padded
// (IMG_W+2) x (IMG_H+2) image in raster order, one byte per clock.
// The border ring is generated internally and consumes no input pixels.
module sharpen_pad_writer #(
   parameter int         IMG_W   = 800,
   parameter int         IMG_H   = 600,
   parameter logic [7:0] PAD_VAL = 8'h00,
   parameter int         AW      = 19
) (
   input logic                 clk,
   input logic                 reset,
   sharpen_pad_writer_if.slave bus
);

   localparam int CW = $clog2(IMG_W + 2);
   localparam int RW = $clog2(IMG_H + 2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W + 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] addr;

   logic border;
   logic at_last;
   logic advance;

   // Position classification and advance decision from the current counters.
   assign border  = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
   assign at_last = (row == ROW_LAST) && (col == COL_LAST);
   assign advance = (state == S_RUN) && (border || bus.in_valid);

   // NOTE: in_ready is a continuous assign of state and counters only, so it
   // can never form a combinational loop through the upstream in_valid and
   // there is no procedural path that could leave it unassigned (no latch).
   assign bus.in_ready = (state == S_RUN) && !border;

   // Frame FSM: walks the padded raster, registers each write one cycle after
   // the advance that produced it, and pulses done alongside the final write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         addr        <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge values of state and counters.
         bus.wr_en <= 1'b0;
         bus.done  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state    <= S_RUN;
                  bus.busy <= 1'b1;
               end
            end
            S_RUN: begin
               if (advance) begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= addr;
                  bus.wr_data <= border ? PAD_VAL : bus.in_data;
                  if (at_last) begin
                     state    <= S_DONE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     addr <= addr + AW'(1);
                     if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + RW'(1);
                     end else begin
                        col <= col + CW'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               col   <= '0;
               row   <= '0;
               addr  <= '0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sharpen_pad_writer.sv
// Scoreboard bench for sharpen_pad_writer on a reduced image size.
// The driver pushes the expected padded-image write sequence per frame; a
// negedge monitor pops and compares every write the DUT presents.
module tb_sharpen_pad_writer;

   localparam int         W      = 8;
   localparam int         H      = 5;
   localparam int         AW     = 7;
   localparam logic [7:0] PAD    = 8'h5A;
   localparam int         NP     = (W + 2) * (H + 2);
   localparam int         BUDGET = 4 * NP + 100;
   localparam int         HOLD   = W + 14;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic          last;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sharpen_pad_writer_if #(.AW(AW)) bus ();

   sharpen_pad_writer #(
      .IMG_W(W), .IMG_H(H), .PAD_VAL(PAD), .AW(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   int         n_vec = 0;
   int         n_err = 0;
   wr_t        exp_q[$];
   int         writes = 0;
   int         done_cnt = 0;
   logic [7:0] pix[W*H];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      check({tag, "_wr_en"},    32'(bus.wr_en), 0);
      check({tag, "_wr_addr"},  32'(bus.wr_addr), 0);
      check({tag, "_wr_data"},  32'(bus.wr_data), 0);
      check({tag, "_busy"},     32'(bus.busy), 0);
      check({tag, "_done"},     32'(bus.done), 0);
   endtask

   // Reference model: the padded image as plain row/column arithmetic.
   task automatic push_expected();
      exp_q.delete();
      for (int a = 0; a < NP; a++) begin
         int  r, c;
         wr_t e;
         r = a / (W + 2);
         c = a % (W + 2);
         e.addr = AW'(a);
         if (r == 0 || r == H + 1 || c == 0 || c == W + 1) e.data = PAD;
         else e.data = pix[(r - 1) * W + (c - 1)];
         e.last = (a == NP - 1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every presented write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         if (bus.wr_en) begin
            writes++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_write: got write to addr %0d expected none", bus.wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
               check("wr_data", 32'(bus.wr_data), 32'(e.data));
               check("done_with_write", 32'(bus.done), 32'(e.last));
            end
         end else begin
            check("done_without_write", 32'(bus.done), 0);
         end
         if (bus.done) done_cnt++;
      end
   end

   // mode 0: continuous, pixel = index mod 256; 1: random stalls;
   // 2: in_valid held low past the first border run; 3: start spam during
   // RUN and in the DONE cycle; 4: reset asserted mid-frame.
   task automatic run_frame(input int mode);
      int k = 0;
      int cyc = 0;
      bit fin = 0;
      bit aborted = 0;
      bit hs;
      bit fin_now;
      for (int i = 0; i < W * H; i++) pix[i] = (mode == 0) ? 8'(i) : 8'($urandom);
      push_expected();
      writes   = 0;
      done_cnt = 0;
      bus.start = 1'b1;
      while (!fin && !aborted && cyc < BUDGET) begin
         case (mode)
            0:       bus.in_valid = 1'b1;
            2:       bus.in_valid = (cyc >= HOLD);
            default: bus.in_valid = ($urandom_range(0, 2) != 0);
         endcase
         bus.in_data = (k < W * H) ? pix[k] : 8'($urandom);
         @(negedge clk);
         hs      = bus.in_valid && bus.in_ready;
         fin_now = bus.done;
         if (fin_now) check("busy_in_done", 32'(bus.busy), 0);
         if (mode == 2 && cyc >= W + 6 && cyc < HOLD) begin
            check("hold_in_ready", 32'(bus.in_ready), 1);
            check("hold_no_write", 32'(bus.wr_en), 0);
            check("hold_last_addr", 32'(bus.wr_addr), W + 2);
         end
         if (mode == 4 && writes >= 40) begin
            #1 reset = 1'b0;
            #1 check_reset_outputs("midframe_reset");
            exp_q.delete();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            aborted = 1;
         end else begin
            @(posedge clk);
            #1;
            if (hs) k++;
            cyc++;
            if (cyc == 1) check("busy_after_start", 32'(bus.busy), 1);
            bus.start = !fin_now && (mode == 3) && (($urandom_range(0, 3) == 0) || bus.done);
            if (fin_now) fin = 1;
         end
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      if (!aborted) begin
         if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: got no done within %0d cycles expected done", BUDGET);
         end
         repeat (4) begin
            @(negedge clk);
            check("post_frame_wr_en", 32'(bus.wr_en), 0);
            check("post_frame_busy", 32'(bus.busy), 0);
         end
         check("post_frame_wr_addr", 32'(bus.wr_addr), NP - 1);
         check("handshakes", 32'(k), W * H);
         check("write_count", 32'(writes), NP);
         check("done_count", 32'(done_cnt), 1);
         check("scoreboard_drained", 32'(exp_q.size()), 0);
      end else begin
         repeat (2) @(negedge clk);
         check_reset_outputs("after_reset_release");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset        = 1'b0;
      // Reset held with random activity on the inputs.
      repeat (20) begin
         @(posedge clk);
         #1;
         bus.start    = 1'($urandom);
         bus.in_valid = 1'($urandom);
         bus.in_data  = 8'($urandom);
         @(negedge clk);
         check_reset_outputs("in_reset");
      end
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_reset_outputs("after_release");
      end
      @(posedge clk);
      #1;
      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(4);
      run_frame(1);
      run_frame(3);
      run_frame(0);
      run_frame(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
